// File: rtl/cfg_reg_arbiter.sv
// cfg_reg_arbiter
//
// Two-port write arbiter in front of the five-entry PWM/output-enable
// configuration register bank. Port 0 is the SPI write-decode path, port 1
// the on-chip sequencer/test port. Round-robin between the ports, one write
// per cycle. A write with lock=1 parks ownership on its port until that port
// completes a write with lock=0.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   sN_valid/addr/data    write request from port N (addr 7 bits, data 8 bits)
//   sN_lock               keep ownership after this write
//   sN_ready              grant to port N (combinational)
//   en_reg_out_7_0        register 0x00
//   en_reg_out_15_8       register 0x01
//   en_reg_pwm_7_0        register 0x02
//   en_reg_pwm_15_8       register 0x03
//   pwm_duty_cycle        register 0x04
//   wr_err                one-cycle pulse after an accepted write to addr > 0x04
//   owner                 arbiter state: 00 unlocked, 01 port 0 owns, 10 port 1 owns
//
// Handshake: a write transfers on the rising edge where sN_valid & sN_ready
// are both high. A requester holds valid, addr, data and lock stable until
// the transfer. sN_ready is never high without sN_valid, and at most one
// ready is high in any cycle, so "some ready is high" means "a transfer
// happens this cycle".
module cfg_reg_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s0_valid,
    input  logic [6:0] s0_addr,
    input  logic [7:0] s0_data,
    input  logic       s0_lock,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [6:0] s1_addr,
    input  logic [7:0] s1_data,
    input  logic       s1_lock,
    output logic       s1_ready,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_err,
    output logic [1:0] owner
);

    // The state encoding is the owner code, so owner is the state flop itself.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            wr_err_q, wr_err_d;
    logic [4:0][7:0] regs_q, regs_d;

    logic            xfer;
    logic            sel;
    logic [6:0]      w_addr;
    logic [7:0]      w_data;
    logic            w_lock;

    // Grant selection. In IDLE a tie goes to the port that did not win the
    // most recent transfer; an owning port is the only one that can be granted.
    always_comb begin
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (s0_valid && s1_valid) begin
                    s0_ready = last_grant_q;
                    s1_ready = ~last_grant_q;
                end else begin
                    s0_ready = s0_valid;
                    s1_ready = s1_valid;
                end
            end
            OWN0:    s0_ready = s0_valid;
            OWN1:    s1_ready = s1_valid;
            default: begin
                s0_ready = 1'b0;
                s1_ready = 1'b0;
            end
        endcase
    end

    // Write path and next-state computation.
    always_comb begin
        xfer   = s0_ready | s1_ready;
        sel    = s1_ready;
        w_addr = sel ? s1_addr : s0_addr;
        w_data = sel ? s1_data : s0_data;
        w_lock = sel ? s1_lock : s0_lock;

        state_d      = state_q;
        last_grant_d = last_grant_q;
        regs_d       = regs_q;
        wr_err_d     = 1'b0;

        if (xfer) begin
            last_grant_d = sel;
            // Lock only matters on a transfer; without one, ownership holds
            // even if the owner drops valid.
            if (w_lock) begin
                state_d = sel ? OWN1 : OWN0;
            end else begin
                state_d = IDLE;
            end
            case (w_addr)
                7'h00:   regs_d[0] = w_data;
                7'h01:   regs_d[1] = w_data;
                7'h02:   regs_d[2] = w_data;
                7'h03:   regs_d[3] = w_data;
                7'h04:   regs_d[4] = w_data;
                default: wr_err_d  = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wr_err_q     <= 1'b0;
            regs_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_err_q     <= wr_err_d;
            regs_q       <= regs_d;
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign wr_err          = wr_err_q;
    assign owner           = state_q;

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Testbench for cfg_reg_arbiter.
//
// The driver applies one cycle of inputs at each falling edge, then a
// behavioural model predicts that cycle's outputs (readies, owner, wr_err,
// register bank) and pushes them into exp_q, plus the expected granted port
// into exp_grant_q whenever it predicts a transfer. A separate monitor
// samples the DUT two time units after the falling edge, pops exp_q every
// cycle and pops exp_grant_q whenever the DUT shows a completed handshake.
module tb_cfg_reg_arbiter;

    localparam int W = 45;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s0_valid, s0_lock, s0_ready;
    logic [6:0] s0_addr;
    logic [7:0] s0_data;
    logic       s1_valid, s1_lock, s1_ready;
    logic [6:0] s1_addr;
    logic [7:0] s1_data;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_err;
    logic [1:0] owner;

    cfg_reg_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s0_valid        (s0_valid),
        .s0_addr         (s0_addr),
        .s0_data         (s0_data),
        .s0_lock         (s0_lock),
        .s0_ready        (s0_ready),
        .s1_valid        (s1_valid),
        .s1_addr         (s1_addr),
        .s1_data         (s1_data),
        .s1_lock         (s1_lock),
        .s1_ready        (s1_ready),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_err          (wr_err),
        .owner           (owner)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    int           exp_grant_q[$];

    // ---------------- reference model ----------------
    // m_own: -1 nobody owns, else owning port. m_last: port of last transfer.
    int         m_own;
    int         m_last;
    logic [7:0] m_regs[5];
    logic       m_err;

    // Pending requests per port, held until the model sees them granted.
    logic       p_v[2];
    logic [6:0] p_a[2];
    logic [7:0] p_d[2];
    logic       p_l[2];

    function automatic void model_reset();
        m_own  = -1;
        m_last = 1;
        m_err  = 1'b0;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    endfunction

    task automatic req(input int p, input logic [6:0] a, input logic [7:0] d, input logic l);
        p_v[p] = 1'b1;
        p_a[p] = a;
        p_d[p] = d;
        p_l[p] = l;
    endtask

    // ---------------- driver ----------------
    task automatic do_cycle(input logic rst_in);
        bit         cand0, cand1;
        int         g;
        logic [1:0] own_code;
        logic       nerr;
        int         a;
        @(negedge clk);
        rst_n    = rst_in;
        s0_valid = rst_in & p_v[0];
        s0_addr  = p_a[0];
        s0_data  = p_d[0];
        s0_lock  = p_l[0];
        s1_valid = rst_in & p_v[1];
        s1_addr  = p_a[1];
        s1_data  = p_d[1];
        s1_lock  = p_l[1];
        #1;
        if (!rst_in) model_reset();
        // A port may be granted if it requests and nobody else owns the bank.
        cand0 = s0_valid && (m_own != 1);
        cand1 = s1_valid && (m_own != 0);
        if (cand0 && cand1)  g = (m_last == 1) ? 0 : 1;
        else if (cand0)      g = 0;
        else if (cand1)      g = 1;
        else                 g = -1;
        own_code = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
        exp_q.push_back({(g == 1), (g == 0), own_code, m_err,
                         m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
        if (rst_in) begin
            nerr = 1'b0;
            if (g >= 0) begin
                exp_grant_q.push_back(g);
                a = int'(p_a[g]);
                if (a < 5) m_regs[a] = p_d[g];
                else       nerr = 1'b1;
                m_own  = p_l[g] ? g : -1;
                m_last = g;
                p_v[g] = 1'b0;
            end
            m_err = nerr;
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] exp_v, act_v;
        int           e, gp;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {s1_ready, s0_ready, owner, wr_err, pwm_duty_cycle,
                         en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
                n_checks++;
                if (act_v === exp_v) n_pass++;
                else $display("FAIL snapshot @%0t: got %h expected %h", $time, act_v, exp_v);
            end
            if ((s0_valid && s0_ready) || (s1_valid && s1_ready)) begin
                gp = s1_ready ? 1 : 0;
                n_checks++;
                if (exp_grant_q.size() == 0) begin
                    $display("FAIL grant @%0t: got port %0d expected no transfer", $time, gp);
                end else begin
                    e = exp_grant_q.pop_front();
                    if (e == gp) n_pass++;
                    else $display("FAIL grant @%0t: got port %0d expected port %0d", $time, gp, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n0, n1;
        rst_n = 1'b0;
        s0_valid = 1'b0; s0_addr = '0; s0_data = '0; s0_lock = 1'b0;
        s1_valid = 1'b0; s1_addr = '0; s1_data = '0; s1_lock = 1'b0;
        for (int p = 0; p < 2; p++) begin
            p_v[p] = 1'b0; p_a[p] = '0; p_d[p] = '0; p_l[p] = 1'b0;
        end
        model_reset();

        repeat (3) do_cycle(1'b0);
        chk("reset_owner", {6'd0, owner}, 8'h00);
        chk("reset_pwm", pwm_duty_cycle, 8'h00);
        do_cycle(1'b1);

        // Single write
        req(0, 7'h04, 8'hA5, 1'b0);
        do_cycle(1'b1);
        chk("single_s0_ready", {7'd0, s0_ready}, 8'h01);
        do_cycle(1'b1);
        chk("single_pwm", pwm_duty_cycle, 8'hA5);
        chk("single_out0", en_reg_out_7_0, 8'h00);
        chk("single_wr_err", {7'd0, wr_err}, 8'h00);

        // Contention from a fresh reset: grants alternate 0,1,0,1
        do_cycle(1'b0);
        do_cycle(1'b1);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 4; i++) begin
            if (!p_v[0]) begin req(0, 7'h00, 8'h11 + 8'(n0), 1'b0); n0++; end
            if (!p_v[1]) begin req(1, 7'h01, 8'h21 + 8'(n1), 1'b0); n1++; end
            do_cycle(1'b1);
            chk("cont_s1_ready", {7'd0, s1_ready}, 8'(i % 2));
        end
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        do_cycle(1'b1);
        chk("cont_out0", en_reg_out_7_0, 8'h12);
        chk("cont_out1", en_reg_out_15_8, 8'h22);

        // Locked burst by port 1 with port 0 requesting
        req(0, 7'h00, 8'h33, 1'b0);
        req(1, 7'h02, 8'h0F, 1'b1);
        do_cycle(1'b1);
        chk("burst_first_s0", {7'd0, s0_ready}, 8'h01);
        req(0, 7'h01, 8'h44, 1'b0);
        do_cycle(1'b1);
        chk("burst_lock_s1", {7'd0, s1_ready}, 8'h01);
        req(1, 7'h03, 8'hF0, 1'b0);
        do_cycle(1'b1);
        chk("burst_owner", {6'd0, owner}, 8'h02);
        chk("burst_s0_blocked", {7'd0, s0_ready}, 8'h00);
        do_cycle(1'b1);
        chk("burst_end_s0", {7'd0, s0_ready}, 8'h01);

        // Bad address
        req(0, 7'h05, 8'hFF, 1'b0);
        do_cycle(1'b1);
        chk("bad_s0_ready", {7'd0, s0_ready}, 8'h01);
        do_cycle(1'b1);
        chk("bad_wr_err", {7'd0, wr_err}, 8'h01);
        chk("bad_out1", en_reg_out_15_8, 8'h44);
        chk("bad_pwm_lo", en_reg_pwm_7_0, 8'h0F);
        chk("bad_pwm_hi", en_reg_pwm_15_8, 8'hF0);
        do_cycle(1'b1);
        chk("bad_wr_err_clear", {7'd0, wr_err}, 8'h00);

        // Reset while port 0 holds a lock
        req(0, 7'h04, 8'h5A, 1'b1);
        do_cycle(1'b1);
        do_cycle(1'b1);
        chk("rstlock_owner_before", {6'd0, owner}, 8'h01);
        do_cycle(1'b0);
        chk("rstlock_owner", {6'd0, owner}, 8'h00);
        chk("rstlock_pwm", pwm_duty_cycle, 8'h00);
        chk("rstlock_out0", en_reg_out_7_0, 8'h00);
        do_cycle(1'b0);
        req(0, 7'h00, 8'h01, 1'b0);
        req(1, 7'h01, 8'h02, 1'b0);
        do_cycle(1'b1);
        chk("rstlock_first_s0", {7'd0, s0_ready}, 8'h01);
        chk("rstlock_first_s1", {7'd0, s1_ready}, 8'h00);
        do_cycle(1'b1);

        // Owner idles while the other port waits
        req(0, 7'h00, 8'h77, 1'b1);
        do_cycle(1'b1);
        req(1, 7'h01, 8'h88, 1'b0);
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b1);
            chk("idle_s1_blocked", {7'd0, s1_ready}, 8'h00);
            chk("idle_owner", {6'd0, owner}, 8'h01);
        end
        req(0, 7'h00, 8'h78, 1'b0);
        do_cycle(1'b1);
        do_cycle(1'b1);
        chk("idle_release_s1", en_reg_out_7_0, 8'h78);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_v[p] && ($urandom_range(0, 99) < 60)) begin
                    req(p,
                        ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 4)) : 7'($urandom_range(5, 127)),
                        8'($urandom_range(0, 255)),
                        ($urandom_range(0, 99) < 25));
                end
            end
            do_cycle($urandom_range(0, 299) != 0);
        end

        p_v[0] = 1'b0; p_v[1] = 1'b0;
        do_cycle(1'b1);
        @(negedge clk);
        #3;
        if (exp_q.size() != 0 || exp_grant_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d/%0d entries left expected 0/0",
                     exp_q.size(), exp_grant_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
